qspi_line_fill: RTL and testbench
=================================

# qspi_line_fill

Line-fill engine sitting between the instruction cache and an external quad-SPI flash/SRAM. When the cache raises `pull` with a line `tag`, it issues a quad-I/O fast read (0xEB) for that line and captures the returned bytes into a line buffer. It then replays the line to the cache as an unbroken burst of nibbles on `dread`/`wstrobe_d`. This is the gap-free, low-nibble-first order the cache's fill counter requires.

## Interface
Parameters:
- `LINE_LENGTH`, 4: cache line length in bytes (power of 2, ≥2); must match the cache.
- `PA`, 22: physical address width; must be ≤ 24.
- `DUMMY`, 4: dummy SCK cycles between address and data.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `pull`  in  1  cache miss request, level.
- `tag`  in  PA-log2(LINE_LENGTH)  line address (paddr[PA-1:log2(LINE_LENGTH)]).
- `dread`  out  4  fill nibble to cache.
- `wstrobe_d`  out  1  `dread` valid this cycle.
- `busy`  out  1  high in every state except IDLE.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_sck`  out  1  serial clock, clk/2.
- `spi_io_out`  out  4  quad data out.
- `spi_io_oe`  out  4  per-line output enable.
- `spi_io_in`  in  4  quad data in.

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, BURST, DONE.
- IDLE: if `pull`=1, latch `tag` and go to CMD. Otherwise stay.
- Each SCK period is 2 clk cycles: phase 0 has `spi_sck`=0, and outputs change only here; phase 1 has `spi_sck`=1.
- `spi_io_in` is sampled on the clk edge that ends phase 1.
- CMD: 2 SCK periods driving nibbles 0xE, then 0xB. `spi_io_oe`=4'hF.
- ADDR: 6 SCK periods, MSB nibble first, `spi_io_oe`=4'hF.
  - 24-bit address = zero-extended {tag, log2(LINE_LENGTH) zero bits}.
- DUMMY: `DUMMY` SCK periods, `spi_io_oe`=0, `spi_io_out`=0.
- DATA: LINE_LENGTH*2 SCK periods, `spi_io_oe`=0.
  - Byte k arrives high nibble first, then low nibble, and is stored at line bits [8k+7:8k].
- BURST: `spi_cs_n`=1, `spi_sck`=0. `wstrobe_d`=1 for exactly LINE_LENGTH*2 consecutive cycles.
  - Strobe n carries `dread` = line[4n+3:4n], i.e. byte n/2, low nibble first.
- DONE: one cycle, `wstrobe_d`=0, `pull` ignored. This lets the cache's valid bit settle so a stale `pull` is not re-served. Then go to IDLE.
- Changes on `pull` or `tag` after latching are ignored; the fetch always completes.
- Reset (any state): next cycle is IDLE. Line buffer contents are don't-care.

## Timing
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_io_out`=0, `spi_io_oe`=0, `wstrobe_d`=0, `dread`=0, `busy`=0.
- Cycle 0 is the cycle in which `pull` is sampled high in IDLE.
- Cycle 1: `spi_cs_n`=0, CMD phase 0.
- Bus phase lasts B = 4 + 12 + 2*DUMMY + 4*LINE_LENGTH cycles. Defaults: B=40, cycles 1..40.
- `spi_cs_n` rises in cycle B+1.
- `wstrobe_d` is high in cycles B+1 .. B+2*LINE_LENGTH (defaults: 41..48).
- DONE occupies cycle B+2*LINE_LENGTH+1 (49). IDLE resumes in the following cycle (50).
- Earliest next `spi_cs_n`=0 is cycle 51. CS high time is therefore ≥ 2*LINE_LENGTH+2 cycles.
- `dread` holds 0 outside BURST.

## Test plan
- Reset → all outputs at their reset values next cycle. `busy`=0. No SCK toggling while `pull`=0.
- Fetch with LINE_LENGTH=4, `tag`=0x5 → bus nibbles E,B,0,0,0,0,1,4. Model returns bytes 12,34,56,78 → `dread`=2,1,4,3,6,5,8,7 in cycles 41–48. With the cache attached, line reads 0x78563412 and hit=1 in cycle 49.
- `pull` held high through DONE (cache hit arrives in cycle 49) → exactly one CS low window; `busy`=0 at cycle 50.
- Assert `reset` in cycle 20 of a fetch → `spi_cs_n`=1 and `busy`=0 next cycle, and no `wstrobe_d`. A following fetch returns correct data.
- `tag` all ones with PA=22 → address nibbles 3,F,F,F,F,C.
- Back-to-back `pull` for tags 1 then 2 → second `spi_cs_n` falls at cycle 51 of the first request. Both bursts are contiguous and 8 strobes long.

Source files
------------

// File: rtl/qspi_line_fill.sv
// Quad-SPI line-fill engine: fetches one cache line with a 0xEB fast read
// and replays it to the cache as a gap-free burst of nibbles, low nibble first.
module qspi_line_fill #(
   parameter int LINE_LENGTH = 4,
   parameter int PA          = 22,
   parameter int DUMMY       = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              pull,
   input  logic [PA-$clog2(LINE_LENGTH)-1:0] tag,
   output logic [3:0]                        dread,
   output logic                              wstrobe_d,
   output logic                              busy,
   output logic                              spi_cs_n,
   output logic                              spi_sck,
   output logic [3:0]                        spi_io_out,
   output logic [3:0]                        spi_io_oe,
   input  logic [3:0]                        spi_io_in
);
   localparam int LB   = $clog2(LINE_LENGTH);
   localparam int TW   = PA - LB;
   localparam int LW   = 8 * LINE_LENGTH;
   localparam int NN   = 2 * LINE_LENGTH;
   localparam int NMAX = (NN > DUMMY) ? ((NN > 6) ? NN : 6) : DUMMY;
   localparam int CW   = $clog2(NMAX);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_BURST, S_DONE
   } state_e;

   state_e        state_q, state_d, nxt;
   logic [CW-1:0] cnt_q, cnt_d, last;
   logic          phase_q, phase_d;
   logic [TW-1:0] tag_q, tag_d;
   logic [LW-1:0] line_q, line_d;
   logic [23:0]   addr;
   logic [CW+1:0] sh;
   logic          on_bus;

   assign addr   = 24'({tag_q, {LB{1'b0}}});
   assign on_bus = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
   assign busy     = (state_q != S_IDLE);
   assign spi_cs_n = ~on_bus;
   assign spi_sck  = on_bus & phase_q;
   // Flash sends each byte high nibble first, so nibble slot = count ^ 1.
   assign sh = {cnt_q ^ CW'(1), 2'b00};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = 1'b0;
      tag_d      = tag_q;
      line_d     = line_q;
      last       = '0;
      nxt        = S_IDLE;
      spi_io_out = 4'h0;
      spi_io_oe  = 4'h0;
      wstrobe_d  = 1'b0;
      dread      = 4'h0;
      unique case (state_q)
         S_IDLE: begin
            if (pull) begin
               tag_d   = tag;
               cnt_d   = '0;
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            last       = CW'(1);
            nxt        = S_ADDR;
            spi_io_oe  = 4'hF;
            spi_io_out = cnt_q[0] ? 4'hB : 4'hE;
         end
         S_ADDR: begin
            last       = CW'(5);
            nxt        = (DUMMY > 0) ? S_DUMMY : S_DATA;
            spi_io_oe  = 4'hF;
            spi_io_out = 4'(addr >> {3'd5 - cnt_q[2:0], 2'b00});
         end
         S_DUMMY: begin
            last = CW'(DUMMY - 1);
            nxt  = S_DATA;
         end
         S_DATA: begin
            last = CW'(NN - 1);
            nxt  = S_BURST;
            if (phase_q) begin
               line_d = (line_q & ~(LW'(4'hF) << sh))
                      | (LW'(spi_io_in) << sh);
            end
         end
         S_BURST: begin
            wstrobe_d = 1'b1;
            dread     = 4'(line_q >> {cnt_q, 2'b00});
            if (cnt_q == CW'(NN - 1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (on_bus) begin
         phase_d = ~phase_q;
         if (phase_q) begin
            if (cnt_q == last) begin
               cnt_d   = '0;
               state_d = nxt;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
      tag_q  <= tag_d;
      line_q <= line_d;
   end
endmodule

// File: tb/tb_qspi_line_fill.sv
// Bench for qspi_line_fill: flash model on the SPI pins, strobe monitor,
// and per-fetch checks of bus content, timing and replayed line data.
module tb_qspi_line_fill;
   localparam int LL = 4;
   localparam int PA = 22;
   localparam int DM = 4;
   localparam int TW = 20;
   localparam int NBUS = 8 + DM + 2 * LL;

   logic          clk = 1'b0;
   logic          reset;
   logic          pull;
   logic [TW-1:0] tag;
   logic [3:0]    dread;
   logic          wstrobe_d, busy, spi_cs_n, spi_sck;
   logic [3:0]    spi_io_out, spi_io_oe;
   logic [3:0]    spi_io_in = 4'h0;

   qspi_line_fill #(.LINE_LENGTH(LL), .PA(PA), .DUMMY(DM)) dut (
      .clk(clk), .reset(reset), .pull(pull), .tag(tag),
      .dread(dread), .wstrobe_d(wstrobe_d), .busy(busy),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
      .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe),
      .spi_io_in(spi_io_in)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [256];
   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      return mem[a[7:0]] ^ a[15:8];
   endfunction

   int         st_cyc[$];
   logic [3:0] st_val[$];
   int         cs_fall[$];
   int         cs_rise[$];
   logic [7:0] nib[$];
   int         idle_sck = 0;
   int         dread_bad = 0;
   logic       cs_prev = 1'b1;
   int         wn = 0;
   logic [23:0] faddr = '0;

   always @(negedge clk) begin
      int d;
      logic [7:0] b;
      if (spi_cs_n === 1'b0 && cs_prev) begin
         cs_fall.push_back(cyc);
         wn = 0;
      end
      if (spi_cs_n === 1'b1 && !cs_prev) cs_rise.push_back(cyc);
      cs_prev = (spi_cs_n !== 1'b0);
      if (spi_cs_n !== 1'b0 && spi_sck !== 1'b0) idle_sck++;
      if (wstrobe_d !== 1'b1 && dread !== 4'h0) dread_bad++;
      if (wstrobe_d === 1'b1) begin
         st_cyc.push_back(cyc);
         st_val.push_back(dread);
      end
      if (spi_cs_n === 1'b0 && spi_sck === 1'b1) begin
         nib.push_back({spi_io_oe, spi_io_out});
         if (wn >= 2 && wn < 8) faddr = {faddr[19:0], spi_io_out};
         d = wn - 8 - DM;
         if (d >= 0 && d < 2 * LL) begin
            b = flash_byte(faddr + 24'(d / 2));
            spi_io_in = (d % 2 == 0) ? b[7:4] : b[3:0];
         end else begin
            spi_io_in = 4'($urandom);
         end
         wn++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   task automatic chk_line(input string nm, input logic [TW-1:0] t,
                           input int base, input int cstart);
      logic [7:0] b;
      for (int n = 0; n < 2 * LL; n++) begin
         b = flash_byte(24'({t, 2'b00}) + 24'(n / 2));
         chk({nm, "_stbcyc"}, st_cyc[base+n], cstart + n);
         chk({nm, "_dread"}, 32'(st_val[base+n]),
             32'((n % 2 == 0) ? b[3:0] : b[7:4]));
      end
   endtask

   task automatic chk_bus(input string nm, input logic [TW-1:0] t,
                          input int base);
      logic [23:0] a;
      logic [7:0]  e;
      a = 24'({t, 2'b00});
      for (int p = 0; p < NBUS; p++) begin
         if (p == 0) e = 8'hFE;
         else if (p == 1) e = 8'hFB;
         else if (p < 8) e = {4'hF, 4'(a >> (4 * (7 - p)))};
         else e = 8'h00;
         chk({nm, "_bus"}, 32'(nib[base+p]), 32'(e));
      end
   endtask

   task automatic fetch(input string nm, input logic [TW-1:0] t,
                        input int drop);
      int c0, fb, sb, nb;
      fb = cs_fall.size();
      sb = st_cyc.size();
      nb = nib.size();
      @(negedge clk);
      c0 = cyc;
      pull = 1'b1;
      tag = t;
      while (cyc < c0 + drop) @(negedge clk);
      pull = 1'b0;
      tag = TW'($urandom);
      while (cyc < c0 + 49) @(negedge clk);
      chk({nm, "_busy49"}, 32'(busy), 1);
      @(negedge clk);
      chk({nm, "_busy50"}, 32'(busy), 0);
      repeat (4) @(negedge clk);
      chk({nm, "_ncs"}, cs_fall.size() - fb, 1);
      chk({nm, "_csfall"}, cs_fall[fb], c0 + 1);
      chk({nm, "_csrise"}, cs_rise[cs_rise.size()-1], c0 + 41);
      chk({nm, "_nstb"}, st_cyc.size() - sb, 2 * LL);
      chk_line(nm, t, sb, c0 + 41);
      chk({nm, "_nnib"}, nib.size() - nb, NBUS);
      chk_bus(nm, t, nb);
   endtask

   initial begin
      int c0, fb, sb;
      reset = 1'b1;
      pull = 1'b0;
      tag = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      chk("reset_outs", {spi_cs_n, spi_sck, spi_io_out, spi_io_oe,
                         wstrobe_d, dread, busy}, 32'h8000);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_cs", 32'(spi_cs_n), 1);

      mem[20] = 8'h12;
      mem[21] = 8'h34;
      mem[22] = 8'h56;
      mem[23] = 8'h78;
      sb = st_cyc.size();
      fetch("tag5", 20'h5, 1);
      chk("tag5_line", {st_val[sb+7], st_val[sb+6], st_val[sb+5],
                        st_val[sb+4], st_val[sb+3], st_val[sb+2],
                        st_val[sb+1], st_val[sb]}, 32'h78563412);

      fetch("hold", 20'h00ABC, 49);
      fetch("ones", 20'hFFFFF, 1);

      sb = st_cyc.size();
      @(negedge clk);
      c0 = cyc;
      pull = 1'b1;
      tag = 20'h00777;
      @(negedge clk);
      pull = 1'b0;
      while (cyc < c0 + 20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_cs", 32'(spi_cs_n), 1);
      chk("rstmid_busy", 32'(busy), 0);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      chk("rstmid_nstb", st_cyc.size() - sb, 0);
      fetch("after_rst", 20'h00777, 1);

      fb = cs_fall.size();
      sb = st_cyc.size();
      @(negedge clk);
      c0 = cyc;
      pull = 1'b1;
      tag = 20'h1;
      @(negedge clk);
      tag = 20'h2;
      while (cyc < c0 + 51) @(negedge clk);
      pull = 1'b0;
      while (cyc < c0 + 105) @(negedge clk);
      chk("b2b_ncs", cs_fall.size() - fb, 2);
      chk("b2b_fall1", cs_fall[fb], c0 + 1);
      chk("b2b_fall2", cs_fall[fb+1], c0 + 51);
      chk("b2b_nstb", st_cyc.size() - sb, 4 * LL);
      chk_line("b2b_t1", 20'h1, sb, c0 + 41);
      chk_line("b2b_t2", 20'h2, sb + 2 * LL, c0 + 91);

      for (int i = 0; i < 6; i++) begin
         fetch("rnd", TW'($urandom), int'($urandom_range(1, 49)));
      end

      chk("idle_sck", idle_sck, 0);
      chk("dread_idle", dread_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
